ram_multi_read_port_clr: RTL
============================

# ram_multi_read_port_clr

Parametrised multi-read-port synchronous RAM: one write port, `NUM_READ_PORTS` independent registered read ports, a selectable read-during-write policy and a hardware clear sweep after reset. It replaces the fixed two-read-port RAM in register-file and operand-fetch paths. Those paths need more read ports, a deterministic post-reset memory content, and a ready indication before first use.

## Interface
Parameters:
- `DATA_WIDTH`, 16, word width in bits.
- `ADDR_WIDTH`, 8, address width in bits.
- `MEM_SIZE`, 256, number of words; valid addresses are 0..MEM_SIZE-1, with MEM_SIZE ≤ 2^ADDR_WIDTH.
- `NUM_READ_PORTS`, 2, number of read ports, ≥ 1.
- `WRITE_FIRST`, 0, read-during-write policy: 0 returns old data, 1 bypasses new data.
- `CLEAR_VALUE`, 0, DATA_WIDTH-bit word written to every location by the clear sweep.

Ports:
- `Clock`  in  1  single clock; all logic is on the rising edge.
- `Reset`  in  1  synchronous, active-high reset; starts the clear sweep.
- `iWriteEnable`  in  1  write request.
- `iWriteAddress`  in  ADDR_WIDTH  write address.
- `iDataIn`  in  DATA_WIDTH  write data.
- `iReadAddress`  in  NUM_READ_PORTS*ADDR_WIDTH  flattened read addresses; port p uses bits [p*ADDR_WIDTH +: ADDR_WIDTH].
- `oDataOut`  out  NUM_READ_PORTS*DATA_WIDTH  flattened registered read data; port p uses bits [p*DATA_WIDTH +: DATA_WIDTH].
- `oReady`  out  1  high when the clear sweep is done and the RAM accepts accesses.
- `oWriteIgnored`  out  1  one-cycle pulse when a write request is discarded.

## Operation
- The FSM has two states, CLEAR and READY, and a clear counter `cnt` of width ADDR_WIDTH.
- Reset sampled high, in any state and at any count:
  - state goes to CLEAR and `cnt` is set to 0;
  - `oReady` = 0, all of `oDataOut` = 0, `oWriteIgnored` = 0;
  - memory is not written on that edge.
- CLEAR, each edge with Reset low:
  - write Ram[cnt] = CLEAR_VALUE;
  - if `cnt` == MEM_SIZE-1, go to READY and set `oReady` = 1; otherwise increment `cnt`.
- CLEAR, reads and writes:
  - `oDataOut` holds 0;
  - `iWriteEnable` = 1 is discarded and pulses `oWriteIgnored` on the next cycle.
- READY, write:
  - if `iWriteEnable` = 1 and `iWriteAddress` < MEM_SIZE, then Ram[iWriteAddress] = iDataIn;
  - if the address is ≥ MEM_SIZE, the write is discarded and `oWriteIgnored` pulses.
- READY, read: every port p registers a value each edge:
  - Ram[addr_p] if addr_p < MEM_SIZE, otherwise CLEAR_VALUE.
- Read-during-write (READY, valid write, addr_p == iWriteAddress):
  - `WRITE_FIRST` = 0: port p returns the pre-write content;
  - `WRITE_FIRST` = 1: port p returns `iDataIn`.
- Any number of ports may read the same address in the same cycle; all return identical data.
- Reset asserted mid-sweep restarts the sweep from address 0.
- Reset asserted in READY discards any write on that edge and re-clears the whole memory.

## Timing
- Read latency is 1 cycle: an address applied before edge N gives data valid after edge N; data holds until the next edge.
- Write latency is 1 cycle: data written at edge N is visible on a read sampled at edge N+1, or at edge N itself when `WRITE_FIRST` = 1.
- Clear sweep length:
  - edge 0 = last edge with Reset high;
  - edges 1..MEM_SIZE perform the writes;
  - `oReady` is high after edge MEM_SIZE;
  - the first read of cleared data is available after edge MEM_SIZE+1.
- `oWriteIgnored` is registered: high for exactly one cycle after the edge that discards the write, low otherwise.
- No combinational path from inputs to outputs.

## Test plan
Unless stated, benches use MEM_SIZE=8, ADDR_WIDTH=4, DATA_WIDTH=16, NUM_READ_PORTS=3, CLEAR_VALUE=16'h0000.
- **Reset and clear:** Reset high 2 cycles, then low; read all addresses after `oReady`.
  - `oReady` is 0 through edge 7 and 1 after edge 8.
  - `oDataOut` = 0 throughout the sweep; every address then reads 0.
- **Write and read:** write 16'hA5A5 to addr 3 and 16'h1234 to addr 5; set ports 0/1/2 to addresses 3/5/3.
  - One cycle later the ports show A5A5, 1234, A5A5.
- **Read-during-write:** with addr 2 = 16'h0001, write 16'hBEEF to addr 2 while port 1 reads addr 2.
  - `WRITE_FIRST`=0: port 1 shows 0001, then BEEF on the next cycle.
  - `WRITE_FIRST`=1: port 1 shows BEEF immediately.
- **Discarded writes:**
  - Write during CLEAR (cnt=3): `oWriteIgnored` pulses once; after the sweep the target address reads 0.
  - Write to addr 9: `oWriteIgnored` pulses; a read of addr 9 returns 0.
- **Reset mid-sweep:** assert Reset at cnt=4, then release.
  - `oReady` rises exactly 8 edges after release, not earlier.
- **Re-clear from READY:** fill all addresses with 16'hFFFF, then reset.
  - All addresses read 0 after `oReady` returns high.
  - A write presented on the reset edge is not stored.

Source files
------------

// File: rtl/ram_multi_read_port_clr.sv
// ---------------------------------------------------------------------------
// ram_multi_read_port_clr
//
// Synchronous RAM with one write port and NUM_READ_PORTS registered read
// ports. After every reset a hardware sweep writes CLEAR_VALUE to every
// location. oReady rises once the sweep has finished, and from that point the
// RAM accepts reads and writes.
//
// Ports
//   Clock          : single clock, rising edge
//   Reset          : synchronous, active high; restarts the clear sweep
//   iWriteEnable   : write request
//   iWriteAddress  : write address
//   iDataIn        : write data
//   iReadAddress   : flattened read addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   oDataOut       : flattened registered read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   oReady         : high when the sweep is done
//   oWriteIgnored  : one-cycle pulse after an edge that discarded a write
//   oDbgState      : FSM state (0 = CLEAR, 1 = READY), for observation only
//
// Read-during-write: when a port reads the address being written in the
// same cycle, WRITE_FIRST = 0 returns the old word and WRITE_FIRST = 1
// returns iDataIn.
// ---------------------------------------------------------------------------
module ram_multi_read_port_clr #(
    parameter int                    DATA_WIDTH     = 16,
    parameter int                    ADDR_WIDTH     = 8,
    parameter int                    MEM_SIZE       = 256,
    parameter int                    NUM_READ_PORTS = 2,
    parameter int                    WRITE_FIRST    = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                                 Clock,
    input  logic                                 Reset,
    input  logic                                 iWriteEnable,
    input  logic [ADDR_WIDTH-1:0]                iWriteAddress,
    input  logic [DATA_WIDTH-1:0]                iDataIn,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] iReadAddress,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] oDataOut,
    output logic                                 oReady,
    output logic                                 oWriteIgnored,
    output logic                                 oDbgState
);

    // The physical array holds only MEM_SIZE words. Its index is just wide
    // enough to cover them. Every access is range-checked on the full
    // address before the index is used.
    localparam int                    IDX_W      = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
    localparam logic [ADDR_WIDTH:0]   MEM_SIZE_W = (ADDR_WIDTH + 1)'(MEM_SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST_CNT   = ADDR_WIDTH'(MEM_SIZE - 1);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t                               state_q, state_d;
    logic [ADDR_WIDTH-1:0]                cnt_q, cnt_d;
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] dout_q, dout_d;
    logic                                 wr_ign_q, wr_ign_d;

    logic [DATA_WIDTH-1:0]                mem_q [0:MEM_SIZE-1];
    logic                                 mem_we;
    logic [IDX_W-1:0]                     mem_widx;
    logic [DATA_WIDTH-1:0]                mem_wdata;

    logic                                 wr_in_range;
    logic                                 wr_valid;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return ({1'b0, addr} < MEM_SIZE_W);
    endfunction

    assign wr_in_range = in_range(iWriteAddress);
    // A write is stored only in READY and only with an in-range address.
    // Reset additionally blocks the memory write on its own edge (see below).
    assign wr_valid    = (state_q == S_READY) && iWriteEnable && wr_in_range;

    // ------------------------------------------------------------------
    // FSM next state, clear counter, write-port steering, discard pulse
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_widx  = iWriteAddress[IDX_W-1:0];
        mem_wdata = iDataIn;
        wr_ign_d  = 1'b0;

        case (state_q)
            S_CLEAR: begin
                // The sweep owns the write port. A user write is dropped
                // and reported.
                mem_we    = 1'b1;
                mem_widx  = cnt_q[IDX_W-1:0];
                mem_wdata = CLEAR_VALUE;
                wr_ign_d  = iWriteEnable;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_READY: begin
                mem_we   = wr_valid;
                wr_ign_d = iWriteEnable && !wr_in_range;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase

        // The reset edge never modifies memory, whatever the state.
        if (Reset) begin
            mem_we = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Read ports: registered, zero while clearing, CLEAR_VALUE for
    // addresses beyond the array.
    // ------------------------------------------------------------------
    always_comb begin
        dout_d = '0;
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            if (state_q == S_READY) begin
                if (!in_range(iReadAddress[p*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    dout_d[p*DATA_WIDTH +: DATA_WIDTH] = CLEAR_VALUE;
                end else if ((WRITE_FIRST != 0) && wr_valid &&
                             (iReadAddress[p*ADDR_WIDTH +: ADDR_WIDTH] == iWriteAddress)) begin
                    dout_d[p*DATA_WIDTH +: DATA_WIDTH] = iDataIn;
                end else begin
                    // mem_q still holds the pre-write word on this edge,
                    // which gives read-old behaviour without extra logic.
                    dout_d[p*DATA_WIDTH +: DATA_WIDTH] = mem_q[iReadAddress[p*ADDR_WIDTH +: IDX_W]];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= S_CLEAR;
            cnt_q    <= '0;
            dout_q   <= '0;
            wr_ign_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            wr_ign_q <= wr_ign_d;
        end
    end

    // The storage array has no reset. The clear sweep defines its contents.
    always_ff @(posedge Clock) begin
        if (mem_we) begin
            mem_q[mem_widx] <= mem_wdata;
        end
    end

    assign oDataOut      = dout_q;
    assign oReady        = (state_q == S_READY);
    assign oWriteIgnored = wr_ign_q;
    assign oDbgState     = state_q;

endmodule
